// File: rtl/clk_gen_prog_downsampler.sv
// rtl/clk_gen_prog_downsampler.sv - runtime-programmable even-ratio clock divider with glitch-free start/stop
module clk_gen_prog_downsampler #(
  parameter int                 WIDTH_P     = 8,
  parameter logic [WIDTH_P-1:0] RESET_DIV_P = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               cfg_v_i,
  input  logic [WIDTH_P-1:0] cfg_data_i,
  output logic               cfg_ready_o,
  output logic               clk_r_o,
  output logic               tick_o,
  output logic [WIDTH_P-1:0] div_o
);

  localparam logic [WIDTH_P-1:0] ONE = {{(WIDTH_P-1){1'b0}}, 1'b1};

  logic [WIDTH_P-1:0] ctr_r;
  logic [WIDTH_P-1:0] div_r;
  logic [WIDTH_P-1:0] pend_val_r;
  logic               pending_r;
  logic               clk_r;
  logic               tick_r;

  logic running;
  logic term;

  // A high phase always runs to completion, so the output only parks while low.
  always_comb begin
    running = en_i | clk_r;
    term    = running & (ctr_r == div_r);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctr_r      <= '0;
      div_r      <= RESET_DIV_P;
      pend_val_r <= '0;
      pending_r  <= 1'b0;
      clk_r      <= 1'b0;
      tick_r     <= 1'b0;
    end else begin
      if (running) begin
        if (term) begin
          ctr_r <= '0;
          clk_r <= ~clk_r;
          if (pending_r) begin
            div_r     <= pend_val_r;
            pending_r <= 1'b0;
          end
        end else begin
          ctr_r <= ctr_r + ONE;
        end
      end else begin
        ctr_r <= '0;
        if (pending_r) begin
          div_r     <= pend_val_r;
          pending_r <= 1'b0;
        end
      end

      tick_r <= term & ~clk_r;

      // Accept only while nothing is pending; never collides with an apply.
      if (cfg_v_i && !pending_r) begin
        pend_val_r <= cfg_data_i;
        pending_r  <= 1'b1;
      end
    end
  end

  assign cfg_ready_o = ~pending_r;
  assign clk_r_o     = clk_r;
  assign tick_o      = tick_r;
  assign div_o       = div_r;

endmodule

// File: tb/tb_clk_gen_prog_downsampler.sv
// tb/tb_clk_gen_prog_downsampler.sv - directed self-checking bench for clk_gen_prog_downsampler
module tb_clk_gen_prog_downsampler;

  logic       clk;
  logic       reset;
  logic       en;
  logic       cfg_v;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       clk_r;
  logic       tick;
  logic [7:0] div;

  int checks = 0;
  int errors = 0;

  clk_gen_prog_downsampler #(.WIDTH_P(8), .RESET_DIV_P(8'd0)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .en_i       (en),
    .cfg_v_i    (cfg_v),
    .cfg_data_i (cfg_data),
    .cfg_ready_o(cfg_ready),
    .clk_r_o    (clk_r),
    .tick_o     (tick),
    .div_o      (div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; cfg_v = 1'b1; cfg_data = 8'd9;
    step();
    step();
    checks++; if (clk_r !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b expected 0", clk_r); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
    checks++; if (div !== 8'd0) begin errors++; $display("FAIL reset_div: got %0d expected 0", div); end
    checks++; if (dut.ctr_r !== 8'd0) begin errors++; $display("FAIL reset_ctr: got %0d expected 0", dut.ctr_r); end
    cfg_v = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_div0();
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (clk_r !== ~i[0]) begin errors++; $display("FAIL div0_clk[%0d]: got %b expected %b", i, clk_r, ~i[0]); end
      checks++; if (tick !== ~i[0]) begin errors++; $display("FAIL div0_tick[%0d]: got %b expected %b", i, tick, ~i[0]); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL div0_ready[%0d]: got %b expected 1", i, cfg_ready); end
    end
  endtask

  task automatic test_cfg_running();
    cfg_v = 1'b1; cfg_data = 8'd3;
    step();
    cfg_v = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfgrun_ready_low: got %b expected 0", cfg_ready); end
    checks++; if (div !== 8'd0) begin errors++; $display("FAIL cfgrun_div_old: got %0d expected 0", div); end
    checks++; if (clk_r !== 1'b1) begin errors++; $display("FAIL cfgrun_clk_a: got %b expected 1", clk_r); end
    step();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfgrun_ready_back: got %b expected 1", cfg_ready); end
    checks++; if (div !== 8'd3) begin errors++; $display("FAIL cfgrun_div_new: got %0d expected 3", div); end
    checks++; if (clk_r !== 1'b0) begin errors++; $display("FAIL cfgrun_clk_b: got %b expected 0", clk_r); end
    for (int j = 0; j < 8; j++) begin
      logic ec;
      logic et;
      ec = (j >= 3) && (j < 7);
      et = (j == 3);
      step();
      checks++; if (clk_r !== ec) begin errors++; $display("FAIL div3_clk[%0d]: got %b expected %b", j, clk_r, ec); end
      checks++; if (tick !== et) begin errors++; $display("FAIL div3_tick[%0d]: got %b expected %b", j, tick, et); end
    end
  endtask

  task automatic test_park();
    for (int j = 0; j < 4; j++) step();
    checks++; if (clk_r !== 1'b1) begin errors++; $display("FAIL park_rise_clk: got %b expected 1", clk_r); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL park_rise_tick: got %b expected 1", tick); end
    en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      logic ec;
      ec = (j < 3);
      step();
      checks++; if (clk_r !== ec) begin errors++; $display("FAIL park_fall_clk[%0d]: got %b expected %b", j, clk_r, ec); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL park_fall_tick[%0d]: got %b expected 0", j, tick); end
    end
    for (int j = 0; j < 6; j++) begin
      step();
      checks++; if (clk_r !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL park_hold[%0d]: got clk=%b tick=%b expected 0 0", j, clk_r, tick); end
    end
    checks++; if (dut.ctr_r !== 8'd0) begin errors++; $display("FAIL park_ctr: got %0d expected 0", dut.ctr_r); end
  endtask

  task automatic test_park_cfg();
    logic [5:0] exp_clk;
    logic [5:0] exp_tick;
    exp_clk  = 6'b100110;
    exp_tick = 6'b100010;
    cfg_v = 1'b1; cfg_data = 8'd1;
    step();
    cfg_v = 1'b0;
    checks++; if (div !== 8'd3) begin errors++; $display("FAIL parkcfg_div_write: got %0d expected 3", div); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL parkcfg_ready_low: got %b expected 0", cfg_ready); end
    step();
    checks++; if (div !== 8'd1) begin errors++; $display("FAIL parkcfg_div_applied: got %0d expected 1", div); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL parkcfg_ready_back: got %b expected 1", cfg_ready); end
    en = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      checks++; if (clk_r !== exp_clk[j]) begin errors++; $display("FAIL start_clk[%0d]: got %b expected %b", j, clk_r, exp_clk[j]); end
      checks++; if (tick !== exp_tick[j]) begin errors++; $display("FAIL start_tick[%0d]: got %b expected %b", j, tick, exp_tick[j]); end
    end
  endtask

  task automatic test_term_cfg();
    cfg_v = 1'b1; cfg_data = 8'd2;
    step();
    cfg_v = 1'b0;
    step();
    checks++; if (div !== 8'd2 || clk_r !== 1'b0) begin errors++; $display("FAIL termcfg_setup: got div=%0d clk=%b expected 2 0", div, clk_r); end
    step();
    step();
    checks++; if (clk_r !== 1'b0) begin errors++; $display("FAIL termcfg_pre: got %b expected 0", clk_r); end
    cfg_v = 1'b1; cfg_data = 8'd5;
    step();
    checks++; if (clk_r !== 1'b1 || tick !== 1'b1) begin errors++; $display("FAIL termcfg_rise: got clk=%b tick=%b expected 1 1", clk_r, tick); end
    checks++; if (div !== 8'd2) begin errors++; $display("FAIL termcfg_div_kept: got %0d expected 2", div); end
    cfg_data = 8'd7;
    for (int j = 0; j < 2; j++) begin
      step();
      checks++; if (cfg_ready !== 1'b0 || clk_r !== 1'b1) begin errors++; $display("FAIL termcfg_hold[%0d]: got ready=%b clk=%b expected 0 1", j, cfg_ready, clk_r); end
    end
    cfg_v = 1'b0;
    step();
    checks++; if (clk_r !== 1'b0) begin errors++; $display("FAIL termcfg_fall: got %b expected 0", clk_r); end
    checks++; if (div !== 8'd5) begin errors++; $display("FAIL termcfg_div_new: got %0d expected 5", div); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL termcfg_ready_back: got %b expected 1", cfg_ready); end
    for (int j = 0; j < 12; j++) begin
      logic ec;
      logic et;
      ec = (j >= 5) && (j < 11);
      et = (j == 5);
      step();
      checks++; if (clk_r !== ec) begin errors++; $display("FAIL div5_clk[%0d]: got %b expected %b", j, clk_r, ec); end
      checks++; if (tick !== et) begin errors++; $display("FAIL div5_tick[%0d]: got %b expected %b", j, tick, et); end
    end
    checks++; if (div !== 8'd5) begin errors++; $display("FAIL termcfg_second_rejected: got %0d expected 5", div); end
  endtask

  task automatic test_reset_mid();
    cfg_v = 1'b1; cfg_data = 8'd7;
    step();
    cfg_v = 1'b0;
    for (int j = 0; j < 4; j++) step();
    step();
    checks++; if (clk_r !== 1'b1 || div !== 8'd7) begin errors++; $display("FAIL rstmid_setup: got clk=%b div=%0d expected 1 7", clk_r, div); end
    step();
    step();
    cfg_v = 1'b1; cfg_data = 8'd4;
    step();
    cfg_v = 1'b0;
    checks++; if (cfg_ready !== 1'b0 || clk_r !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got ready=%b clk=%b expected 0 1", cfg_ready, clk_r); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    en = 1'b0;
    checks++; if (clk_r !== 1'b0) begin errors++; $display("FAIL rstmid_clk: got %b expected 0", clk_r); end
    checks++; if (div !== 8'd0) begin errors++; $display("FAIL rstmid_div: got %0d expected 0", div); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", cfg_ready); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rstmid_tick: got %b expected 0", tick); end
    step();
    step();
    checks++; if (div !== 8'd0) begin errors++; $display("FAIL rstmid_pending_cleared: got %0d expected 0", div); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; cfg_v = 1'b0; cfg_data = 8'd0;
    test_reset();
    test_div0();
    test_cfg_running();
    test_park();
    test_park_cfg();
    test_term_cfg();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_gen_prog_downsampler.md
Name: clk_gen_prog_downsampler

Overview:
Parametrised, runtime-programmable successor to the fixed clk_gen delay stages. It divides clk_i by an even ratio 2*(div+1), with div set through a valid/ready config port. Ratio changes take effect only at a half-period boundary, so the output has no runt pulses. Start and stop are likewise glitch-free. It sits after the clock generator and produces the downsampled core clock plus a rising-edge strobe.

Parameters:
WIDTH_P, 8, width of the divide value and the internal counter
RESET_DIV_P, 0, divide value loaded on reset (WIDTH_P bits; 0 = divide-by-2)

Ports:
clk_i  input  1  source clock; all logic is on its rising edge
reset_i  input  1  synchronous, active-high reset
en_i  input  1  run enable; low requests a glitch-free park with clk_r_o low
cfg_v_i  input  1  config valid
cfg_data_i  input  WIDTH_P  new divide value
cfg_ready_o  output  1  config ready; equals ~pending_r
clk_r_o  output  1  registered divided clock
tick_o  output  1  one-cycle pulse, high in the same cycle clk_r_o first reads 1 after a rise
div_o  output  WIDTH_P  divide value currently in effect

Behaviour:
- Reset values (the cycle after reset_i is sampled high): ctr_r=0, div_r=RESET_DIV_P, pending_r=0, pend_val_r=0, clk_r_o=0, tick_o=0, cfg_ready_o=1. Reset overrides all other inputs, including a cfg handshake in the same cycle.
- Reset asserted mid-period: clk_r_o goes to 0 on the next edge (a truncated period is acceptable only on reset).
- Terminal event (term): running & (ctr_r==div_r).
- States:
  - RUN = en_i | clk_r_o.
  - PARK = ~en_i & ~clk_r_o.
- RUN behaviour:
  - ctr_r increments each cycle.
  - On term: ctr_r<=0 and clk_r_o<=~clk_r_o.
  - Half-period = div_r+1 cycles.
- RUN to PARK: en_i falls while clk_r_o=1. Counting continues to term, clk_r_o falls, and the block then parks. If en_i falls while clk_r_o=0, the block parks immediately: ctr_r<=0 and clk_r_o stays 0.
- PARK behaviour: ctr_r is held at 0 and there are no toggles.
- PARK to RUN: en_i rises. ctr_r counts from 0. The first rise of clk_r_o occurs div_r+1 cycles after the first cycle en_i is sampled high.
- Config handshake:
  - A transfer occurs when cfg_v_i & cfg_ready_o. It sets pend_val_r<=cfg_data_i and pending_r<=1.
  - cfg_ready_o is low while pending_r=1; cfg_v_i is ignored then.
- Config apply:
  - In RUN: on term with pending_r=1, div_r<=pend_val_r and pending_r<=0. The new value governs the next half-period.
  - In PARK: the pending value is applied on the next cycle.
  - A transfer accepted in the same cycle as term is not applied at that term; it is applied at the following term.
- tick_o: high for exactly one cycle per clk_r_o rising transition; tick_o=0 when clk_r_o falls.
- Width rules:
  - ctr_r is WIDTH_P bits. It never exceeds div_r, so there is no wrap.
  - div=0 gives a period of 2 cycles; div=2^WIDTH_P-1 gives a period of 2^(WIDTH_P+1) cycles.
- div_o always reflects div_r. It changes only at an apply point.

Test Plan:
- Reset, en_i=1, RESET_DIV_P=0 -> clk_r_o toggles every cycle (period 2); tick_o pulses every 2nd cycle; cfg_ready_o=1.
- While running at div=0, write cfg 3 -> cfg_ready_o low until the next toggle. From then, half-periods are 4 cycles (period 8) and div_o=3.
- div=3, drop en_i one cycle after a clk_r_o rise -> clk_r_o stays high for the full 4 cycles, falls, then stays 0. No tick_o follows and ctr_r holds at 0.
- Parked, write cfg 1, then raise en_i -> div_o=1 one cycle after the write. The first clk_r_o rise is 2 cycles after en_i is sampled; period is 4.
- Write cfg 5 exactly on a term cycle at div=2 -> the next half-period is still 3 cycles, and half-periods of 6 cycles begin at the following toggle. A second cfg_v_i held during pending is not accepted.
- Assert reset_i mid high phase at div=7 -> next cycle clk_r_o=0, div_o=RESET_DIV_P, pending cleared, cfg_ready_o=1.
